// File: rtl/fpga_link_pkg.sv
// rtl/fpga_link_pkg.sv - shared types and defaults for the FPGA-to-FPGA serial link
package fpga_link_pkg;

    localparam int LINK_DATA_WIDTH   = 8;
    localparam int LINK_CLKS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/fpga_serial_transmitter_if.sv
// rtl/fpga_serial_transmitter_if.sv - byte handshake between upstream source and serial transmitter
interface fpga_serial_transmitter_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/fpga_link_bit_timer.sv
// rtl/fpga_link_bit_timer.sv - bit-period counter with a registered end-of-period tick
module fpga_link_bit_timer
    import fpga_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_COUNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    // tick is registered one count early so it lands in the period's final cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!run) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == LAST_COUNT) ? '0 : count + CW'(1);
            tick  <= (count == PRE_COUNT);
        end
    end

endmodule

// File: rtl/fpga_serial_transmitter.sv
// rtl/fpga_serial_transmitter.sv - parallel-to-serial transmit stage with per-bit sample strobe
module fpga_serial_transmitter
    import fpga_link_pkg::*;
#(
    parameter int DATA_WIDTH   = LINK_DATA_WIDTH,
    parameter int CLKS_PER_BIT = LINK_CLKS_PER_BIT,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    fpga_serial_transmitter_if.slave    tx,
    output logic                        serial_out,
    output logic                        shift_out,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] hold_shifted;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;
    logic                  accept;
    logic                  last_bit;
    logic                  first_bit;
    logic                  next_bit;

    assign tx.tx_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign last_bit    = (bit_cnt == LAST_BIT);

    // The bit on the wire is always the leading end of the hold register
    assign hold_shifted = MSB_FIRST ? {hold[DATA_WIDTH-2:0], 1'b0} : {1'b0, hold[DATA_WIDTH-1:1]};
    assign first_bit    = MSB_FIRST ? tx.tx_data[DATA_WIDTH-1] : tx.tx_data[0];
    assign next_bit     = MSB_FIRST ? hold_shifted[DATA_WIDTH-1] : hold_shifted[0];

    fpga_link_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .run   (state == SHIFT),
        .tick  (tick)
    );

    assign shift_out = tick;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (tick && last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold       <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= 1'b0;
                    if (accept) begin
                        hold       <= tx.tx_data;
                        bit_cnt    <= '0;
                        serial_out <= first_bit;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        hold    <= hold_shifted;
                        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                        if (last_bit) begin
                            serial_out <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            serial_out <= next_bit;
                        end
                    end
                end
                default: begin
                    serial_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_serial_transmitter.sv
// tb/tb_fpga_serial_transmitter.sv - directed bench for the serial transmitter (MSB- and LSB-first instances)
module tb_fpga_serial_transmitter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fpga_serial_transmitter_if #(.DATA_WIDTH(8)) if_m ();
    fpga_serial_transmitter_if #(.DATA_WIDTH(8)) if_l ();

    logic serial_m, shift_m, busy_m, done_m;
    logic serial_l, shift_l, busy_l, done_l;

    fpga_serial_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) dut_m (
        .clock      (clock),
        .reset      (reset),
        .tx         (if_m.slave),
        .serial_out (serial_m),
        .shift_out  (shift_m),
        .busy       (busy_m),
        .frame_done (done_m)
    );

    fpga_serial_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) dut_l (
        .clock      (clock),
        .reset      (reset),
        .tx         (if_l.slave),
        .serial_out (serial_l),
        .shift_out  (shift_l),
        .busy       (busy_l),
        .frame_done (done_l)
    );

    // receiver model standing in for fpga_shift_register
    logic [7:0] rx = 8'h00;
    always @(posedge clock) if (shift_m) rx <= {rx[6:0], serial_m};

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic [7:0] order;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // {serial_out, shift_out, frame_done, tx_ready, busy}
    function automatic logic [4:0] outs(input bit sel);
        return sel ? {serial_l, shift_l, done_l, if_l.tx_ready, busy_l}
                   : {serial_m, shift_m, done_m, if_m.tx_ready, busy_m};
    endfunction

    task automatic drive(input bit sel, input logic [7:0] data, input logic valid);
        if (sel) begin
            if_l.tx_data  = data;
            if_l.tx_valid = valid;
        end else begin
            if_m.tx_data  = data;
            if_m.tx_valid = valid;
        end
    endtask

    task automatic start(input bit sel, input logic [7:0] data);
        logic [4:0] o;
        bit ok;
        ok = 1'b0;
        drive(sel, data, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            o = outs(sel);
            if (o[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("start_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_frame(input bit sel, input logic [7:0] data, input logic [7:0] order,
                               input logic keep_valid, input logic [7:0] alt);
        logic [4:0] exp;
        drive(sel, alt, keep_valid);
        for (int n = 1; n <= 34; n++) begin
            @(negedge clock);
            if (n <= 32)      exp = {order[7 - (n - 1) / 4], (n % 4) == 0, 1'b0, 1'b0, 1'b1};
            else if (n == 33) exp = 5'b00101;
            else              exp = 5'b00010;
            check($sformatf("frame_%02h_cycle_%0d", data, n), 32'(outs(sel)), 32'(exp));
            if (!sel && n == 33 && data == 8'h5A) check("loopback_data_out", 32'(rx), 32'h5A);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int strobes;
        vecs[0] = '{1'b0, 8'hA5, 8'b10100101};
        vecs[1] = '{1'b0, 8'h5A, 8'b01011010};
        vecs[2] = '{1'b1, 8'h01, 8'b10000000};
        vecs[3] = '{1'b1, 8'h35, 8'b10101100};
        vecs[4] = '{1'b1, 8'h80, 8'b00000001};

        reset = 1'b0;
        drive(1'b0, 8'hA5, 1'b1);
        drive(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("reset_msb_%0d", i), 32'(outs(1'b0)), 32'(5'b00010));
            check($sformatf("reset_lsb_%0d", i), 32'(outs(1'b1)), 32'(5'b00010));
        end
        @(posedge clock);
        #1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_idle", 32'(outs(1'b0)), 32'(5'b00010));

        for (int v = 0; v < 5; v++) begin
            start(vecs[v].sel, vecs[v].data);
            check_frame(vecs[v].sel, vecs[v].data, vecs[v].order, 1'b0, ~vecs[v].data);
        end

        start(1'b0, 8'h3C);
        check_frame(1'b0, 8'h3C, 8'b00111100, 1'b1, 8'hC3);
        @(posedge clock);
        #1;
        check_frame(1'b0, 8'hC3, 8'b11000011, 1'b0, 8'h00);

        start(1'b0, 8'hFF);
        drive(1'b0, 8'h00, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        check("pre_reset_serial", 32'(serial_m), 32'd1);
        reset = 1'b0;
        #1;
        check("reset_async", 32'(outs(1'b0)), 32'(5'b00010));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (shift_m || busy_m) strobes++;
        end
        check("no_strobes_after_reset", 32'(strobes), 32'd0);
        check("idle_after_reset", 32'(outs(1'b0)), 32'(5'b00010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpga_serial_transmitter.md
# fpga_serial_transmitter

Parallel-to-serial transmit stage for the FPGA-to-FPGA link. It accepts one byte per valid/ready handshake and shifts it out one bit at a time on `serial_out`. Each bit is paired with a single-cycle `shift_out` strobe. It sits directly upstream of `fpga_shift_register`: `serial_out` drives that block's `data_in`, and `shift_out` drives its `shift`. Both FPGAs share `clock`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per frame.
- `CLKS_PER_BIT`, 4: clock cycles per bit period. Legal values are 2 or more.
- `MSB_FIRST`, 1: 1 sends bit `DATA_WIDTH-1` first; 0 sends bit 0 first.

Ports:
- `clock`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tx_data`  in  DATA_WIDTH: byte to send. Sampled only on an accept edge.
- `tx_valid`  in  1: upstream has a byte to send.
- `tx_ready`  out  1: block can accept a byte (high only in IDLE).
- `serial_out`  out  1: serial bit to the receiver.
- `shift_out`  out  1: one-cycle strobe telling the receiver to sample `serial_out`.
- `busy`  out  1: a frame is in progress (state is not IDLE).
- `frame_done`  out  1: one-cycle pulse after the last bit's strobe.

## Operation
- FSM states:
  - **IDLE:** `tx_ready`=1 and `serial_out`=0. On an edge with `tx_valid`&&`tx_ready`, load `tx_data` into the hold register, clear the bit and period counters, and go to SHIFT.
  - **SHIFT:** drive the current bit on `serial_out` for `CLKS_PER_BIT` cycles. Assert `shift_out` in the last cycle of each period, then advance the bit counter. After the strobe for bit `DATA_WIDTH-1`, go to DONE.
  - **DONE:** hold for one cycle with `frame_done`=1, `serial_out`=0, `tx_ready`=0. Then go to IDLE. This gap gives the receiver one cycle to consume its parallel output.
- Bit selection:
  - The hold register shifts by one position after each strobe. Bit order is set by `MSB_FIRST`.
  - The bit counter is `$clog2(DATA_WIDTH)` wide and the period counter is `$clog2(CLKS_PER_BIT)` wide. Both wrap to 0 without overflow.
- `tx_valid` and `tx_data` are ignored whenever `tx_ready`=0. A byte changed mid-frame does not affect the frame in flight.
- All outputs are registered, except `tx_ready` and `busy`, which decode the state register directly.
- Reset values: state IDLE, `tx_ready`=1, `serial_out`=0, `shift_out`=0, `busy`=0, `frame_done`=0. Hold register and counters are 0.
- Reset mid-frame: on `reset` low, all outputs go to their reset values immediately (asynchronously) and the partial byte is discarded. No further `shift_out` strobes occur. After release, the block is in IDLE.

## Timing
- Cycle numbering: the accept edge is edge 0, and cycle n is the interval after edge n-1. Let C = `CLKS_PER_BIT`.
- Bit i is on `serial_out` in cycles i·C+1 through (i+1)·C.
- `shift_out`=1 only in cycle (i+1)·C.
- `frame_done`=1 in cycle `DATA_WIDTH`·C+1.
- `tx_ready`=1 again from cycle `DATA_WIDTH`·C+2. A waiting byte is accepted on that cycle's edge.
- Throughput is one byte per `DATA_WIDTH`·C+2 cycles. With defaults, that is 34 cycles.
- `serial_out` never changes in a cycle where `shift_out`=1. It is stable for the whole bit period.

## Structure
- Shared package `fpga_link_pkg` holds:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - default constants `LINK_DATA_WIDTH`=8 and `LINK_CLKS_PER_BIT`=4.
- One sub-module, `fpga_link_bit_timer`:
  - contains the period counter with parameter `CLKS_PER_BIT`;
  - inputs are `clock`, `reset`, and `run`;
  - output is `tick`, high in the last cycle of each period;
  - it is reused by the future receive-side framer.
- The FSM, hold register and bit counter live in `fpga_serial_transmitter`.

## Test plan
- **Reset:** hold `reset` low for 3 cycles with `tx_valid`=1. Required: `tx_ready`=1, all other outputs 0, and no accept occurs while reset is low.
- **Single byte, MSB first:** send 0xA5 with C=4. Required: `serial_out` sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles; `shift_out` high in cycles 4, 8, …, 32; `frame_done` in cycle 33; `tx_ready` high in cycle 34.
- **Back-to-back:** send 0x3C then 0xC3 with `tx_valid` held high. Required: the second byte is accepted at edge 34, and data changed during the first frame has no effect on that frame.
- **LSB first:** with `MSB_FIRST`=0, send 0x01. Required: first bit 1, remaining seven bits 0.
- **Reset mid-frame:** start 0xFF and pull `reset` low in cycle 10. Required: `serial_out`, `shift_out` and `busy` go to 0 at once; no strobes occur after release; `tx_ready`=1.
- **Loopback:** drive `fpga_shift_register` from `serial_out` and `shift_out`, then send 0x5A. Required: the receiver's `data_out`=0x5A in the `frame_done` cycle.
